instr_mem_loadable: RTL
=======================

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 Parameter IW, default 9, instruction width in bits.
REQ-002 Parameter AW, default 10, address width; depth DEPTH = 2**AW.
REQ-003 Parameter NOP, default 9'b101100100, fill value for unwritten or cleared words (IW bits).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 fetch_en  input  1  fetch request in RUN.
REQ-007 pc  input  AW  fetch address.
REQ-008 instr  output  IW  registered fetched instruction.
REQ-009 instr_valid  output  1  instr holds a fetch result.
REQ-010 ld_valid  input  1  load word offered.
REQ-011 ld_ready  output  1  load word accepted this cycle when ld_valid=1.
REQ-012 ld_data  input  IW  load word.
REQ-013 ld_last  input  1  final load word; qualified by ld_valid&&ld_ready.
REQ-014 boot_skip  input  1  leave LOAD with no further words.
REQ-015 reload  input  1  restart CLEAR from RUN.
REQ-016 run  output  1  state is RUN.
REQ-017 par_err  output  1  sticky parity error flag (see Configuration).

Function
REQ-018 FSM states CLEAR, LOAD, RUN; encoding free.
REQ-019 CLEAR: write NOP to address clr_ptr each cycle, clr_ptr 0..DEPTH-1; after writing DEPTH-1, next state LOAD; duration exactly DEPTH cycles.
REQ-020 LOAD: ld_ready=1; each ld_valid&&ld_ready writes ld_data at ld_ptr, ld_ptr increments; ld_ptr starts at 0 on LOAD entry.
REQ-021 LOAD exits to RUN the cycle after an accepted word with ld_last=1, or accepted word at ld_ptr=DEPTH-1 (no wrap), or boot_skip=1.
REQ-022 boot_skip and an accepted word in the same cycle: word is written, then RUN.
REQ-023 ld_ready=0 in CLEAR and RUN; ld_valid ignored there.
REQ-024 RUN: fetch_en=1 -> next cycle instr=mem[pc], instr_valid=1 (latency 1).
REQ-025 RUN: fetch_en=0 -> instr and instr_valid hold (stall).
REQ-026 reload=1 in RUN -> next state CLEAR, instr_valid=0 next cycle; reload beats simultaneous fetch_en. reload ignored outside RUN.
REQ-027 Outside RUN: instr_valid=0, instr=NOP.
REQ-028 run=1 exactly when state is RUN.
REQ-029 Memory contents are not reset; correctness relies on CLEAR.

Reset
REQ-030 rst_n low asynchronously forces: state CLEAR, clr_ptr=0, ld_ptr=0, instr=NOP, instr_valid=0, ld_ready=0, run=0, par_err=0.
REQ-031 Reset mid-CLEAR/LOAD/RUN aborts the operation; after release CLEAR restarts from address 0.
REQ-032 No memory write occurs while rst_n is low.

Configuration
REQ-033 Macro INSTR_MEM_PARITY_EN defined: each word stores IW+1 bits, the extra bit is even parity of the data, written in CLEAR and LOAD; each RUN fetch checks parity and on mismatch sets par_err next cycle, held until reset or reload.
REQ-034 Macro INSTR_MEM_PARITY_EN undefined: storage IW bits, par_err tied 0, no other behavioural difference.

Verification
REQ-035 Reset, idle DEPTH cycles -> LOAD entered at cycle DEPTH, ld_ready=1; boot_skip=1 -> run=1 next cycle; fetch pc=5 -> instr=9'b101100100, instr_valid=1.
REQ-036 Load 3 words 9'h011, 9'h022, 9'h033 (last flagged) with ld_valid gaps -> run=1; fetch pc=0,1,2 back-to-back -> instr 9'h011, 9'h022, 9'h033 on consecutive cycles.
REQ-037 In RUN fetch pc=1 then fetch_en=0 for 4 cycles -> instr=9'h022, instr_valid=1 held throughout.
REQ-038 reload with fetch_en=1 same cycle -> instr_valid=0 next cycle, run=0, DEPTH CLEAR cycles, then skip and fetch pc=0 -> NOP.
REQ-039 Assert rst_n=0 mid-LOAD after 2 words -> outputs at reset values immediately; after release full CLEAR, previously loaded words read NOP.
REQ-040 With INSTR_MEM_PARITY_EN, force a stored bit flip at pc=2, fetch pc=2 -> par_err=1 next cycle, stays 1 until reload.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - instruction memory with CLEAR/LOAD/RUN boot sequencer
// Optional feature macro: INSTR_MEM_PARITY_EN (per-word even parity with sticky par_err)
module instr_mem_loadable #(
    parameter int             IW  = 9,
    parameter int             AW  = 10,
    parameter logic [IW-1:0]  NOP = 9'b101100100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    input  logic [AW-1:0] pc,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [IW-1:0] ld_data,
    input  logic          ld_last,
    input  logic          boot_skip,
    input  logic          reload,
    output logic          run,
    output logic          par_err
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);
`ifdef INSTR_MEM_PARITY_EN
    localparam int WW = IW + 1;
`else
    localparam int WW = IW;
`endif

    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] ld_ptr;
    logic [WW-1:0] mem [DEPTH];
    logic [WW-1:0] rd_word;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [WW-1:0] mem_wdata;

    function automatic logic [WW-1:0] encode(input logic [IW-1:0] d);
`ifdef INSTR_MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign ld_ready = (state == S_LOAD);
    assign run      = (state == S_RUN);
    assign rd_word  = mem[pc];

    // Write enable is gated by rst_n so the held-in-CLEAR state never writes during reset.
    assign mem_we    = rst_n && ((state == S_CLEAR) || ((state == S_LOAD) && ld_valid));
    assign mem_waddr = (state == S_CLEAR) ? clr_ptr : ld_ptr;
    assign mem_wdata = (state == S_CLEAR) ? encode(NOP) : encode(ld_data);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_CLEAR;
            clr_ptr     <= '0;
            ld_ptr      <= '0;
            instr       <= NOP;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    instr       <= NOP;
                    instr_valid <= 1'b0;
                    clr_ptr     <= clr_ptr + AW'(1);
                    if (clr_ptr == PTR_MAX) begin
                        state  <= S_LOAD;
                        ld_ptr <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        ld_ptr <= ld_ptr + AW'(1);
                        if (ld_last || (ld_ptr == PTR_MAX)) begin
                            state <= S_RUN;
                        end
                    end
                    if (boot_skip) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        state       <= S_CLEAR;
                        clr_ptr     <= '0;
                        instr       <= NOP;
                        instr_valid <= 1'b0;
                    end else if (fetch_en) begin
                        instr       <= rd_word[IW-1:0];
                        instr_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    // Even parity over data plus stored bit is zero for an intact word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (state == S_RUN) begin
            if (reload) begin
                par_err <= 1'b0;
            end else if (fetch_en && (^rd_word)) begin
                par_err <= 1'b1;
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule
